mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port 32-bit memory between the CPU's instruction-fetch port (i_*) and data port (d_*).
- Enables a multi-cycle or stalled CPU variant built around the existing single-cycle datapath.
- Accepts one request at a time, drives a fixed-latency memory, and returns a one-cycle ack with registered read data.
- Tie arbitration is round-robin; alignment faults are reported without touching memory.

Parameters:
- MEM_LAT, 1: memory read latency in cycles from the mem_en cycle to mem_rdata valid. Legal range 1..15; 4-bit counter.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- d_req  in  1  data-port request, held until d_ack
- d_addr  in  32  data byte address
- d_we  in  1  1 = store, 0 = load
- d_wdata  in  32  store data
- d_rdata  out  32  load data, valid while d_ack=1
- d_ack  out  1  one-cycle completion pulse
- d_err  out  1  misaligned-access flag, valid while d_ack=1
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  32  fetch byte address
- i_rdata  out  32  instruction word, valid while i_ack=1
- i_ack  out  1  one-cycle completion pulse
- i_err  out  1  misaligned-fetch flag, valid while i_ack=1
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: single clock `clock`; reset `resetn` is asynchronous, active-low.
- Reset values: state=IDLE; last_gnt=1 (port 1 = fetch); counter=0; all outputs 0. Reset mid-transaction drops it immediately, and mem_en falls asynchronously.
- All outputs are registered.
- State IDLE:
  - Requests are sampled only here.
  - Only one port requesting: that port wins.
  - Both requesting: the port not granted last wins. First tie after reset goes to data (port 0).
  - On a win, latch port id, addr, we (fetch forces we=0) and wdata; update last_gnt.
  - addr[1:0]!=0: go to RESP with err=1. No memory access.
  - Otherwise go to ACCESS.
- State ACCESS (1 cycle): mem_en=1; mem_we, mem_addr and mem_wdata driven from the latch; counter loaded with MEM_LAT; go to WAIT.
- State WAIT:
  - mem_en=0; mem_addr, mem_we and mem_wdata hold their values.
  - Counter decrements each cycle.
  - In the cycle the counter equals 1, mem_rdata is sampled into the granted port's rdata register, and the state goes to RESP.
- State RESP (1 cycle): granted port's ack=1. Its rdata holds the sampled word (0 for writes and errors); err as latched. Go to IDLE.
- Outputs of the non-granted port stay 0 in all states.
- Latency: request seen in IDLE at cycle 0 -> mem_en at cycle 1 -> ack at cycle MEM_LAT+2. Misaligned requests ack at cycle 1.
- Back-to-back throughput: one access per MEM_LAT+3 cycles.
- Requester protocol:
  - Drop req, or present a new request, in the cycle after ack.
  - req still high in IDLE is treated as a new transaction.
  - Changes to addr/we/wdata after the IDLE grant cycle are ignored.
  - A requester losing arbitration keeps req high and waits with no timeout. Round-robin bounds the wait to one competing transaction.
- Simultaneous events: a request arriving during ACCESS/WAIT/RESP is not seen until the next IDLE.

Optional Feature:
- Macro: MEM_ARB_DPRIO_EN.
- Defined: fixed priority. The data port always wins ties and last_gnt is unused.
- Undefined: round-robin as above.
- All other timing is identical.

Test Plan:
- MEM_LAT=1, i_req only, i_addr=0x0000_0010, mem returns 0x0010_0093 -> mem_en pulse at cycle 1 with mem_addr=0x10 and mem_we=0; i_ack at cycle 3 with i_rdata=0x0010_0093 and i_err=0; d_ack stays 0.
- MEM_LAT=3, d_req store, d_addr=0x40, d_wdata=0xDEAD_BEEF -> mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF for exactly one cycle; d_ack at cycle 5; d_rdata=0.
- d_req and i_req both held high from reset, 4 transactions -> grants D, I, D, I; each ack is 1 cycle; busy drops for one IDLE cycle between transactions. With MEM_ARB_DPRIO_EN defined -> grants D, D, D, D.
- d_addr=0x0000_0006 load -> no mem_en; d_ack and d_err at cycle 1; d_rdata=0.
- resetn pulsed low during WAIT (MEM_LAT=4) -> mem_en, busy and all acks read 0 immediately; after release, the first access restarts in IDLE and last_gnt=1.
- MEM_LAT=15 fetch -> ack exactly at cycle 17; mem_rdata sampled only in the final WAIT cycle, with garbage values in earlier cycles ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch and data ports, fixed-latency memory.
// Define MEM_ARB_DPRIO_EN for fixed data-port priority on ties.
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ack,
  output logic        i_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t      r_state;
  logic        r_port;
  logic [3:0]  r_cnt;
  logic        w_any;
  logic        w_gnt;
  logic        w_mis;
  logic [31:0] w_addr;
`ifndef MEM_ARB_DPRIO_EN
  logic        r_last_gnt;
`endif

  // Port id: 0 = data, 1 = fetch.
  always_comb begin
    w_any = d_req | i_req;
`ifdef MEM_ARB_DPRIO_EN
    w_gnt = i_req & ~d_req;
`else
    w_gnt = (d_req & i_req) ? ~r_last_gnt : i_req;
`endif
    w_addr = w_gnt ? i_addr : d_addr;
    w_mis  = |w_addr[1:0];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_port    <= 1'b0;
      r_cnt     <= '0;
`ifndef MEM_ARB_DPRIO_EN
      r_last_gnt <= 1'b1;
`endif
      d_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      i_rdata   <= '0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_port <= w_gnt;
`ifndef MEM_ARB_DPRIO_EN
            r_last_gnt <= w_gnt;
`endif
            busy <= 1'b1;
            // Misaligned: answer straight away, memory untouched.
            if (w_mis) begin
              r_state <= RESP;
              i_ack   <= w_gnt;
              i_err   <= w_gnt;
              d_ack   <= ~w_gnt;
              d_err   <= ~w_gnt;
            end else begin
              r_state   <= ACCESS;
              mem_en    <= 1'b1;
              mem_we    <= ~w_gnt & d_we;
              mem_addr  <= w_addr;
              mem_wdata <= w_gnt ? '0 : d_wdata;
            end
          end
        end
        ACCESS: begin
          mem_en  <= 1'b0;
          r_cnt   <= LAT;
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
            if (r_port) begin
              i_ack   <= 1'b1;
              i_rdata <= mem_rdata;
            end else begin
              d_ack   <= 1'b1;
              d_rdata <= mem_we ? '0 : mem_rdata;
            end
          end
        end
        RESP: begin
          d_ack   <= 1'b0;
          d_err   <= 1'b0;
          d_rdata <= '0;
          i_ack   <= 1'b0;
          i_err   <= 1'b0;
          i_rdata <= '0;
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: four instances, MEM_LAT 1/3/4/15.
module tb_mem_port_arbiter;

  localparam int NI = 4;
  localparam int unsigned LATS [NI] = '{1, 3, 4, 15};

  logic        clock;
  logic        resetn;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_we;
  logic [31:0] d_wdata;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] mem_rdata;

  logic [31:0] d_rdata   [NI];
  logic        d_ack     [NI];
  logic        d_err     [NI];
  logic [31:0] i_rdata   [NI];
  logic        i_ack     [NI];
  logic        i_err     [NI];
  logic        mem_en    [NI];
  logic        mem_we    [NI];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic        busy      [NI];

  int n_cmp;
  int n_bad;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_port_arbiter #(.MEM_LAT(LATS[g])) u_dut (
      .clock     (clock),
      .resetn    (resetn),
      .d_req     (d_req),
      .d_addr    (d_addr),
      .d_we      (d_we),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata[g]),
      .d_ack     (d_ack[g]),
      .d_err     (d_err[g]),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata[g]),
      .i_ack     (i_ack[g]),
      .i_err     (i_err[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata),
      .busy      (busy[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clr_inputs();
    d_req = 0; d_addr = 0; d_we = 0; d_wdata = 0;
    i_req = 0; i_addr = 0; mem_rdata = 0;
  endtask

  // Leaves the bench at a negedge with every instance in IDLE.
  task automatic do_reset();
    @(negedge clock);
    resetn = 0;
    clr_inputs();
    @(negedge clock);
    resetn = 1;
  endtask

  task automatic test_reset();
    logic [6:0] f;
    logic [31:0] w;
    resetn = 0;
    d_req = 1; i_req = 1; d_we = 1;
    d_addr = 32'h44; i_addr = 32'h48;
    d_wdata = 32'hFFFF_FFFF; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clock);
    for (int k = 0; k < NI; k++) begin
      f = {d_ack[k], d_err[k], i_ack[k], i_err[k],
           mem_en[k], mem_we[k], busy[k]};
      w = d_rdata[k] | i_rdata[k] | mem_addr[k] | mem_wdata[k];
      n_cmp++;
      if (f !== 7'd0) begin
        n_bad++;
        $display("FAIL reset_flags[%0d]: got %b want 0", k, f);
      end
      n_cmp++;
      if (w !== 32'd0) begin
        n_bad++;
        $display("FAIL reset_data[%0d]: got %h want 0", k, w);
      end
    end
    clr_inputs();
    @(negedge clock);
    resetn = 1;
    @(negedge clock);
    n_cmp++;
    if (busy[0] !== 1'b0 || mem_en[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b en=%b want 0 0",
               busy[0], mem_en[0]);
    end
  endtask

  task automatic test_fetch_lat1();
    int en_n = 0, en_c = -1, ack_n = 0, ack_c = -1, dack = 0;
    do_reset();
    i_addr = 32'h10; i_req = 1; mem_rdata = 32'h0010_0093;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      if (d_ack[0]) dack++;
      if (mem_en[0]) begin
        en_n++; en_c = c;
        n_cmp++;
        if (mem_addr[0] !== 32'h10 || mem_we[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL fetch_mem: addr=%h we=%b want 10 0",
                   mem_addr[0], mem_we[0]);
        end
      end
      if (i_ack[0]) begin
        ack_n++; ack_c = c; i_req = 0;
        n_cmp++;
        if (i_rdata[0] !== 32'h0010_0093 || i_err[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL fetch_data: rdata=%h err=%b want 00100093 0",
                   i_rdata[0], i_err[0]);
        end
      end
    end
    n_cmp++;
    if (en_n !== 1 || en_c !== 1) begin
      n_bad++;
      $display("FAIL fetch_en: count=%0d cyc=%0d want 1 1", en_n, en_c);
    end
    n_cmp++;
    if (ack_n !== 1 || ack_c !== 3) begin
      n_bad++;
      $display("FAIL fetch_ack: count=%0d cyc=%0d want 1 3", ack_n, ack_c);
    end
    n_cmp++;
    if (dack !== 0) begin
      n_bad++;
      $display("FAIL fetch_dack: got %0d want 0", dack);
    end
  endtask

  task automatic test_store_lat3();
    int en_n = 0, ack_n = 0, ack_c = -1;
    do_reset();
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h1234_5678;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (mem_en[1]) begin
        en_n++;
        n_cmp++;
        if (mem_we[1] !== 1'b1 || mem_wdata[1] !== 32'hDEAD_BEEF ||
            mem_addr[1] !== 32'h40) begin
          n_bad++;
          $display("FAIL store_mem: we=%b wd=%h a=%h want 1 deadbeef 40",
                   mem_we[1], mem_wdata[1], mem_addr[1]);
        end
      end
      if (d_ack[1]) begin
        ack_n++; ack_c = c; d_req = 0;
        n_cmp++;
        if (d_rdata[1] !== 32'd0 || d_err[1] !== 1'b0) begin
          n_bad++;
          $display("FAIL store_rdata: rdata=%h err=%b want 0 0",
                   d_rdata[1], d_err[1]);
        end
      end
    end
    n_cmp++;
    if (en_n !== 1) begin
      n_bad++;
      $display("FAIL store_en: count=%0d want 1", en_n);
    end
    n_cmp++;
    if (ack_n !== 1 || ack_c !== 5) begin
      n_bad++;
      $display("FAIL store_ack: count=%0d cyc=%0d want 1 5", ack_n, ack_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq = '0;
    logic [3:0] exp_seq;
    int cyc [4];
    int n = 0, c = 0;
`ifdef MEM_ARB_DPRIO_EN
    exp_seq = 4'b0000;
`else
    exp_seq = 4'b1010;
`endif
    do_reset();
    d_req = 1; i_req = 1; d_addr = 32'h20; i_addr = 32'h30;
    mem_rdata = 32'h55;
    while (n < 4 && c < 40) begin
      @(negedge clock); c++;
      if (d_ack[0] && i_ack[0]) begin
        n_cmp++; n_bad++;
        $display("FAIL rr_both: both acks high at cycle %0d", c);
      end
      if (d_ack[0] || i_ack[0]) begin
        seq[n] = i_ack[0]; cyc[n] = c; n++;
        @(negedge clock); c++;
        n_cmp++;
        if (d_ack[0] || i_ack[0] || busy[0]) begin
          n_bad++;
          $display("FAIL rr_gap: dack=%b iack=%b busy=%b want 0 0 0",
                   d_ack[0], i_ack[0], busy[0]);
        end
      end
    end
    n_cmp++;
    if (n !== 4 || seq !== exp_seq) begin
      n_bad++;
      $display("FAIL rr_seq: n=%0d seq=%b want 4 %b", n, seq, exp_seq);
    end
    for (int j = 0; j < n; j++) begin
      n_cmp++;
      if (cyc[j] !== 3 + 4 * j) begin
        n_bad++;
        $display("FAIL rr_cyc[%0d]: got %0d want %0d", j, cyc[j], 3 + 4 * j);
      end
    end
    d_req = 0; i_req = 0;
  endtask

  task automatic test_misaligned();
    int en_n = 0;
    do_reset();
    d_req = 1; d_we = 0; d_addr = 32'h6; mem_rdata = 32'hFFFF_FFFF;
    @(negedge clock);
    if (mem_en[0]) en_n++;
    n_cmp++;
    if (d_ack[0] !== 1'b1 || d_err[0] !== 1'b1 || d_rdata[0] !== 32'd0 ||
        busy[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL mis_d: ack=%b err=%b rd=%h busy=%b want 1 1 0 1",
               d_ack[0], d_err[0], d_rdata[0], busy[0]);
    end
    d_req = 0;
    @(negedge clock);
    if (mem_en[0]) en_n++;
    n_cmp++;
    if (d_ack[0] !== 1'b0 || d_err[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mis_d_clear: ack=%b err=%b busy=%b want 0 0 0",
               d_ack[0], d_err[0], busy[0]);
    end
    i_req = 1; i_addr = 32'h2;
    @(negedge clock);
    if (mem_en[0]) en_n++;
    n_cmp++;
    if (i_ack[0] !== 1'b1 || i_err[0] !== 1'b1 || d_ack[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL mis_i: iack=%b ierr=%b dack=%b want 1 1 0",
               i_ack[0], i_err[0], d_ack[0]);
    end
    i_req = 0;
    @(negedge clock);
    if (mem_en[0]) en_n++;
    n_cmp++;
    if (en_n !== 0) begin
      n_bad++;
      $display("FAIL mis_en: count=%0d want 0", en_n);
    end
  endtask

  task automatic test_reset_wait();
    int ack_c = -1;
    logic ack_i = 1'b1;
    do_reset();
    d_req = 1; d_addr = 32'h80; d_we = 0; mem_rdata = 32'h77;
    @(negedge clock);
    d_req = 0;
    @(negedge clock);
    n_cmp++;
    if (busy[2] !== 1'b1 || mem_en[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL rw_wait: busy=%b en=%b want 1 0", busy[2], mem_en[2]);
    end
    #2 resetn = 0;
    #1;
    n_cmp++;
    if (busy[2] !== 1'b0 || mem_en[2] !== 1'b0 || d_ack[2] !== 1'b0 ||
        i_ack[2] !== 1'b0 || mem_addr[2] !== 32'd0) begin
      n_bad++;
      $display("FAIL rw_async: busy=%b en=%b da=%b ia=%b a=%h want 0",
               busy[2], mem_en[2], d_ack[2], i_ack[2], mem_addr[2]);
    end
    @(negedge clock);
    resetn = 1;
    d_req = 1; i_req = 1; i_addr = 32'h90;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if ((d_ack[2] || i_ack[2]) && ack_c < 0) begin
        ack_c = c; ack_i = i_ack[2];
      end
    end
    d_req = 0; i_req = 0;
    n_cmp++;
    if (ack_c !== 6 || ack_i !== 1'b0) begin
      n_bad++;
      $display("FAIL rw_restart: cyc=%0d port=%b want 6 0", ack_c, ack_i);
    end
  endtask

  task automatic test_lat15();
    int ack_n = 0, ack_c = -1;
    do_reset();
    i_req = 1; i_addr = 32'h100; mem_rdata = 32'hBAD0_0000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (i_ack[3]) begin
        ack_n++; ack_c = c; i_req = 0;
        n_cmp++;
        if (i_rdata[3] !== 32'hCAFE_F00D) begin
          n_bad++;
          $display("FAIL lat15_data: got %h want cafef00d", i_rdata[3]);
        end
      end
      mem_rdata = (c == 16) ? 32'hCAFE_F00D : (32'hBAD0_0000 | 32'(c));
    end
    n_cmp++;
    if (ack_n !== 1 || ack_c !== 17) begin
      n_bad++;
      $display("FAIL lat15_ack: count=%0d cyc=%0d want 1 17", ack_n, ack_c);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clr_inputs();
    test_reset();
    test_fetch_lat1();
    test_store_lat3();
    test_back_to_back();
    test_misaligned();
    test_reset_wait();
    test_lat15();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
